// File: rtl/i2c_arb_pkg.sv
// Shared types and default limits for the two-port I2C transaction arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER,
    RESP
  } state_t;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
  } i2c_cmd_t;

  localparam int START_TIMEOUT_DEF = 16;
  localparam int XFER_TIMEOUT_DEF  = 65535;
  localparam int TO_W_DEF          = 16;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side handshake bundle: two request ports in, one shared response out.
interface i2c_txn_arbiter_if;

  logic [1:0]      req_valid;
  logic [1:0]      req_rw;
  logic [1:0][6:0] req_addr;
  logic [1:0][7:0] req_wdata;
  logic [1:0]      req_ready;
  logic [1:0]      resp_valid;
  logic [7:0]      resp_rdata;
  logic            resp_err;
  logic            resp_timeout;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_timeout
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_timeout
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; 'last' is the port granted most recently.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || last)) begin
      grant[0] = 1'b1;
    end else if (req[1]) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Sequencer in front of the single I2C master: arbitrates two requesters, runs
// one byte transaction at a time and returns a per-owner response pulse.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int XFER_TIMEOUT  = XFER_TIMEOUT_DEF,
  parameter int TO_W          = TO_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  i2c_txn_arbiter_if.slave   bus,
  output logic               enable,
  output logic               RW,
  output logic [6:0]         slaveAdd,
  output logic [7:0]         data_in,
  input  logic               busy,
  input  logic               ackerror,
  input  logic [7:0]         data_out
);

  localparam logic [TO_W-1:0] START_LIM = TO_W'(START_TIMEOUT - 1);
  localparam logic [TO_W-1:0] XFER_LIM  = TO_W'(XFER_TIMEOUT - 1);

  state_t          state;
  i2c_cmd_t        cmd;
  logic            owner;
  logic            last_grant;
  logic            ack_seen;
  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_next;
  logic [1:0]      grant;
  logic            sel;
  logic            accept;

  rr_arb2 u_rr_arb2 (
    .req   (bus.req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  // Ready is only offered while idle, so a grant never overlaps a response.
  assign bus.req_ready = (state == IDLE) ? grant : 2'b00;
  assign sel           = grant[1];
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign cnt_next      = (cnt == '1) ? cnt : cnt + 1'b1;

  assign RW       = cmd.rw;
  assign slaveAdd = cmd.addr;
  assign data_in  = cmd.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cmd              <= '0;
      owner            <= 1'b0;
      last_grant       <= 1'b1;
      ack_seen         <= 1'b0;
      cnt              <= '0;
      enable           <= 1'b0;
      bus.resp_valid   <= 2'b00;
      bus.resp_rdata   <= 8'h00;
      bus.resp_err     <= 1'b0;
      bus.resp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd.rw     <= bus.req_rw[sel];
            cmd.addr   <= bus.req_addr[sel];
            cmd.wdata  <= bus.req_wdata[sel];
            owner      <= sel;
            last_grant <= sel;
            enable     <= 1'b1;
            cnt        <= '0;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          if (busy) begin
            enable   <= 1'b0;
            cnt      <= '0;
            ack_seen <= 1'b0;
            state    <= XFER;
          end else if (cnt == START_LIM) begin
            enable           <= 1'b0;
            cnt              <= '0;
            bus.resp_valid   <= owner ? 2'b10 : 2'b01;
            bus.resp_rdata   <= 8'h00;
            bus.resp_err     <= 1'b1;
            bus.resp_timeout <= 1'b1;
            state            <= RESP;
          end else begin
            cnt <= cnt_next;
          end
        end

        // ackerror is folded in on the busy-fall cycle as well as while busy.
        XFER: begin
          if (!busy) begin
            cnt              <= '0;
            bus.resp_valid   <= owner ? 2'b10 : 2'b01;
            bus.resp_rdata   <= (cmd.rw && !(ack_seen || ackerror)) ? data_out : 8'h00;
            bus.resp_err     <= ack_seen | ackerror;
            bus.resp_timeout <= 1'b0;
            state            <= RESP;
          end else if (cnt == XFER_LIM) begin
            cnt              <= '0;
            bus.resp_valid   <= owner ? 2'b10 : 2'b01;
            bus.resp_rdata   <= 8'h00;
            bus.resp_err     <= 1'b1;
            bus.resp_timeout <= 1'b1;
            state            <= RESP;
          end else begin
            cnt      <= cnt_next;
            ack_seen <= ack_seen | ackerror;
          end
        end

        RESP: begin
          cnt              <= '0;
          bus.resp_valid   <= 2'b00;
          bus.resp_rdata   <= 8'h00;
          bus.resp_err     <= 1'b0;
          bus.resp_timeout <= 1'b0;
          state            <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Sequencer and two-port arbiter in front of the single I2C master. It accepts byte transactions from two requesters (port 0: processor memory-mapped bridge; port 1: autonomous sensor poller), grants one at a time round-robin, and drives the master's `enable`/`RW`/`slaveAdd`/`data_in`. It tracks `busy` to completion, captures `data_out`, and returns a per-transaction response carrying ACK and timeout error status.

## Interface
Parameters:
- `START_TIMEOUT`, 16: maximum cycles `enable` is held without `busy` rising before the transaction aborts.
- `XFER_TIMEOUT`, 65535: maximum cycles `busy` may stay high before the transaction aborts.
- `TO_W`, 16: timeout counter width; must hold both limits.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in [1:0]: per-port request.
- `req_rw` in [1:0]: 1 = read, 0 = write.
- `req_addr` in [1:0][6:0]: 7-bit slave address per port.
- `req_wdata` in [1:0][7:0]: write byte per port.
- `req_ready` out [1:0]: accept strobe, at most one bit high.
- `resp_valid` out [1:0]: one-cycle completion pulse to the owning port.
- `resp_rdata` out 8: read byte; 0 for writes and errors.
- `resp_err` out 1: ACK error or timeout; valid with `resp_valid`.
- `resp_timeout` out 1: error cause was a timeout.
- `enable` out 1: to I2C master.
- `RW` out 1: to I2C master.
- `slaveAdd` out 7: to I2C master.
- `data_in` out 8: to I2C master.
- `busy` in 1: from I2C master.
- `ackerror` in 1: from I2C master.
- `data_out` in 8: from I2C master.

## Operation
- States: IDLE, ISSUE, XFER, RESP.
- IDLE:
  - `req_ready` is combinational. It is set for the granted port when any `req_valid` is high.
  - Grant: if both ports request, the port not granted last wins. The round-robin pointer resets to prefer port 0.
  - Handshake is `req_valid & req_ready`. At that edge, latch rw/addr/wdata and the owner id, then go to ISSUE.
  - Requesters hold valid and payload stable until ready.
- ISSUE:
  - `enable`=1. `RW`, `slaveAdd` and `data_in` are driven from the latched command.
  - `busy`=1 sampled: go to XFER and deassert `enable`.
  - Counter reaches `START_TIMEOUT` first: go to RESP with err=1, timeout=1.
- XFER:
  - `enable`=0. Command outputs are held stable.
  - Sticky flag `ack_seen` sets on any cycle where `ackerror`=1.
  - `busy`=0 sampled: capture `data_out` if read, and set err=`ack_seen | ackerror`. Go to RESP.
  - Counter reaches `XFER_TIMEOUT`: go to RESP with err=1, timeout=1, rdata=0.
- RESP:
  - Registered `resp_valid[owner]`=1 for exactly one cycle, with `resp_rdata`/`resp_err`/`resp_timeout`. Then return to IDLE.
  - `req_ready` is 0 here, so a new grant is never overlapped with a response.
- The timeout counter clears on every state entry and saturates. Write transactions return `resp_rdata`=0.
- Reset mid-transaction: return to IDLE immediately and drop `enable`. No response is issued for the aborted command. The requester must re-issue it.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `resp_timeout`=0, `enable`=0, `RW`=0, `slaveAdd`=0, `data_in`=0. State IDLE, pointer favours port 0.
- Handshake edge N: `enable`=1 from cycle N+1.
- `busy` sampled high at edge M: `enable`=0 from cycle M+1.
- `busy` sampled low at edge K: `resp_valid` high in cycle K+1, low in K+2. `req_ready` may assert again in cycle K+2.
- Minimum request-to-response: 4 cycles plus the master's busy duration.
- Start timeout: `resp_valid` is asserted `START_TIMEOUT`+1 cycles after entering ISSUE.
- `ackerror` is sampled only during XFER and the busy-fall cycle. Pulses outside those windows are ignored.

## Structure
- Package `i2c_arb_pkg` holds:
  - `state_t` enum (IDLE, ISSUE, XFER, RESP).
  - `i2c_cmd_t` struct (rw, addr[6:0], wdata[7:0]).
  - Default timeout constants.
- Sub-module `rr_arb2`: combinational two-way round-robin grant from `req_valid` and a last-grant pointer. The pointer is updated by the parent on handshake.

## Test plan
- Single write, port 0:
  - Stimulus: addr 0x36, data 0xA5, `busy` high 3 cycles after `enable`, low 20 cycles later, no `ackerror`.
  - Response: master sees `slaveAdd`=0x36, `data_in`=0xA5, `RW`=0. `resp_valid[0]` pulses once with err=0 and rdata=0.
- Read, port 1:
  - Stimulus: `data_out`=0x5C at busy fall.
  - Response: `resp_valid[1]`, `resp_rdata`=0x5C, err=0. `RW`=1 throughout.
- Contention:
  - Stimulus: both ports request continuously for 4 transactions.
  - Response: grants alternate 0,1,0,1. Never two `req_ready` bits high. `resp_valid` always goes to the owner.
- ACK error:
  - Stimulus: single-cycle `ackerror` pulse mid-XFER.
  - Response: `resp_err`=1, `resp_timeout`=0.
- Start timeout:
  - Stimulus: `START_TIMEOUT`=4, `busy` held 0.
  - Response: `enable` high 4 cycles, then `resp_err`=1, `resp_timeout`=1, `enable`=0.
- Reset in XFER:
  - Stimulus: assert `rst` while `busy`=1.
  - Response: `enable`=0 and IDLE immediately. No `resp_valid`. The next request is granted to port 0 first.
